// File: rtl/inst_decode_fwd_if.sv
// Decode-stage bus: fetch instruction, pipeline bypass/hazard inputs and the
// resolved ID/EX register fields. The decode stage itself attaches as slave.
interface inst_decode_fwd_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 32
);
    localparam int ADDR_W = $clog2(NREG);

    logic [31:0]       IR;
    logic              IN_VALID;
    logic [DATA_W-1:0] NPC_IN;
    logic              FLUSH;
    logic [ADDR_W-1:0] RD_EXE;
    logic [ADDR_W-1:0] RD_MEM;
    logic [ADDR_W-1:0] RD_WB;
    logic              WR_EXE;
    logic              WR_MEM;
    logic              LOAD_EXE;
    logic              COND_WB;
    logic [DATA_W-1:0] EXE_OUT;
    logic [DATA_W-1:0] MEM_ACC_OUT;
    logic [DATA_W-1:0] WB_OUT;

    logic [DATA_W-1:0] REG_A;
    logic [DATA_W-1:0] REG_B;
    logic [DATA_W-1:0] IMM;
    logic [DATA_W-1:0] NPC_OUT;
    logic [4:0]        OPCD;
    logic [ADDR_W-1:0] ADDR_REG;
    logic              OPT_BIT;
    logic              OUT_VALID;
    logic              STALL;
    logic [2:0]        ESTADO;

    modport master (
        output IR, IN_VALID, NPC_IN, FLUSH, RD_EXE, RD_MEM, RD_WB, WR_EXE, WR_MEM,
               LOAD_EXE, COND_WB, EXE_OUT, MEM_ACC_OUT, WB_OUT,
        input  REG_A, REG_B, IMM, NPC_OUT, OPCD, ADDR_REG, OPT_BIT, OUT_VALID,
               STALL, ESTADO
    );

    modport slave (
        input  IR, IN_VALID, NPC_IN, FLUSH, RD_EXE, RD_MEM, RD_WB, WR_EXE, WR_MEM,
               LOAD_EXE, COND_WB, EXE_OUT, MEM_ACC_OUT, WB_OUT,
        output REG_A, REG_B, IMM, NPC_OUT, OPCD, ADDR_REG, OPT_BIT, OUT_VALID,
               STALL, ESTADO
    );
endinterface

// File: rtl/inst_decode_fwd.sv
// Instruction decode stage: register file, operand bypass, RAW stall, ID/EX register.
// Build option ID_FWD_EN: enables EXE/MEM bypass (only load-use stalls); otherwise stall until WB.
module inst_decode_fwd #(
    parameter int         DATA_W  = 16,
    parameter int         NREG    = 32,
    parameter logic [4:0] NOP_OPC = 5'd0
) (
    input logic              CLK,
    input logic              RST,
    inst_decode_fwd_if.slave bus
);
    localparam int ADDR_W = $clog2(NREG);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_RUN   = 3'd1,
        S_STALL = 3'd2,
        S_FLUSH = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    data_t      rf_q [NREG];
    data_t      rf_d [NREG];
    data_t      reg_a_q, reg_a_d, reg_b_q, reg_b_d;
    data_t      imm_q, imm_d, npc_q, npc_d;
    logic [4:0] opcd_q, opcd_d;
    addr_t      addr_reg_q, addr_reg_d;
    logic       opt_q, opt_d;
    logic       valid_q, valid_d;

    addr_t rd, rs1, rs2;
    logic  opt;
    data_t imm_ext, op_a, op_b;
    logic  hazard, stall;

    assign rd      = bus.IR[22 +: ADDR_W];
    assign rs1     = bus.IR[17 +: ADDR_W];
    assign rs2     = bus.IR[12 +: ADDR_W];
    assign opt     = bus.IR[11];
    assign imm_ext = DATA_W'($signed(bus.IR[15:0]));

    // A producer hits a source only when it writes a non-zero register equal to it.
    function automatic logic src_hit(input logic wr, input addr_t dst, input addr_t idx);
        return wr && (idx != '0) && (dst == idx);
    endfunction

    function automatic data_t resolve(input addr_t idx, input data_t rf_val);
        data_t v;
        v = rf_val;
        if (idx == '0)
            v = '0;
`ifdef ID_FWD_EN
        else if (src_hit(bus.WR_EXE, bus.RD_EXE, idx))
            v = bus.EXE_OUT;
        else if (src_hit(bus.WR_MEM, bus.RD_MEM, idx))
            v = bus.MEM_ACC_OUT;
`endif
        else if (src_hit(bus.COND_WB, bus.RD_WB, idx))
            v = bus.WB_OUT;
        return v;
    endfunction

    always_comb begin
        op_a = resolve(rs1, rf_q[rs1]);
        op_b = resolve(rs2, rf_q[rs2]);
`ifdef ID_FWD_EN
        hazard = bus.LOAD_EXE &&
                 (src_hit(bus.WR_EXE, bus.RD_EXE, rs1) ||
                  (!opt && src_hit(bus.WR_EXE, bus.RD_EXE, rs2)));
`else
        hazard = src_hit(bus.WR_EXE, bus.RD_EXE, rs1) || src_hit(bus.WR_MEM, bus.RD_MEM, rs1) ||
                 (!opt && (src_hit(bus.WR_EXE, bus.RD_EXE, rs2) ||
                           src_hit(bus.WR_MEM, bus.RD_MEM, rs2)));
`endif
        stall = bus.IN_VALID && hazard && !bus.FLUSH && !RST;
    end

`ifndef ID_FWD_EN
    logic unused_bypass;
    assign unused_bypass = ^{bus.EXE_OUT, bus.MEM_ACC_OUT, bus.LOAD_EXE};
`endif

    always_comb begin
        rf_d = rf_q;
        if (bus.COND_WB && bus.RD_WB != '0)
            rf_d[bus.RD_WB] = bus.WB_OUT;
    end

    // Bubbles carry NOP_OPC with every other field zeroed.
    always_comb begin
        reg_a_d    = '0;
        reg_b_d    = '0;
        imm_d      = '0;
        npc_d      = '0;
        opcd_d     = NOP_OPC;
        addr_reg_d = '0;
        opt_d      = 1'b0;
        valid_d    = 1'b0;
        if (bus.IN_VALID && !bus.FLUSH && !stall) begin
            reg_a_d    = op_a;
            reg_b_d    = op_b;
            imm_d      = imm_ext;
            npc_d      = bus.NPC_IN;
            opcd_d     = bus.IR[31:27];
            addr_reg_d = rd;
            opt_d      = opt;
            valid_d    = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_RESET)
            state_d = S_IDLE;
        else if (bus.FLUSH)
            state_d = S_FLUSH;
        else if (stall)
            state_d = S_STALL;
        else if (bus.IN_VALID)
            state_d = S_RUN;
        else
            state_d = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_RESET;
            rf_q       <= '{default: '0};
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            imm_q      <= '0;
            npc_q      <= '0;
            opcd_q     <= NOP_OPC;
            addr_reg_q <= '0;
            opt_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            reg_a_q    <= reg_a_d;
            reg_b_q    <= reg_b_d;
            imm_q      <= imm_d;
            npc_q      <= npc_d;
            opcd_q     <= opcd_d;
            addr_reg_q <= addr_reg_d;
            opt_q      <= opt_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.REG_A     = reg_a_q;
    assign bus.REG_B     = reg_b_q;
    assign bus.IMM       = imm_q;
    assign bus.NPC_OUT   = npc_q;
    assign bus.OPCD      = opcd_q;
    assign bus.ADDR_REG  = addr_reg_q;
    assign bus.OPT_BIT   = opt_q;
    assign bus.OUT_VALID = valid_q;
    assign bus.STALL     = stall;
    assign bus.ESTADO    = state_q;
endmodule

// File: tb/tb_inst_decode_fwd.sv
// Directed bench for inst_decode_fwd (DATA_W=32); expectations follow the ID_FWD_EN setting.
module tb_inst_decode_fwd;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    inst_decode_fwd_if #(.DATA_W(32), .NREG(32)) bus ();

    inst_decode_fwd #(.DATA_W(32), .NREG(32), .NOP_OPC(5'd0)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic opt);
        return {opc, rd, rs1, rs2, opt, 11'd0};
    endfunction

    task automatic clear_bus();
        bus.IR          = '0;
        bus.IN_VALID    = 1'b0;
        bus.NPC_IN      = '0;
        bus.FLUSH       = 1'b0;
        bus.RD_EXE      = '0;
        bus.RD_MEM      = '0;
        bus.RD_WB       = '0;
        bus.WR_EXE      = 1'b0;
        bus.WR_MEM      = 1'b0;
        bus.LOAD_EXE    = 1'b0;
        bus.COND_WB     = 1'b0;
        bus.EXE_OUT     = '0;
        bus.MEM_ACC_OUT = '0;
        bus.WB_OUT      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_bus();
        bus.IR       = $urandom();
        bus.NPC_IN   = $urandom();
        bus.IN_VALID = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_stall", 32'(bus.STALL), 32'd0);
        check_val("rst_reg_a", bus.REG_A, 32'd0);
        check_val("rst_reg_b", bus.REG_B, 32'd0);
        check_val("rst_imm", bus.IMM, 32'd0);
        check_val("rst_npc", bus.NPC_OUT, 32'd0);
        check_val("rst_opcd", 32'(bus.OPCD), 32'd0);
        check_val("rst_addr", 32'(bus.ADDR_REG), 32'd0);
        check_val("rst_opt", 32'(bus.OPT_BIT), 32'd0);
        check_val("rst_valid", 32'(bus.OUT_VALID), 32'd0);
        check_val("rst_estado", 32'(bus.ESTADO), 32'd0);

        rst = 1'b0;
        clear_bus();
        tick();
        check_val("idle_estado", 32'(bus.ESTADO), 32'd4);
        check_val("idle_valid", 32'(bus.OUT_VALID), 32'd0);

        // WB write and same-cycle read of R27
        bus.IN_VALID = 1'b1;
        bus.IR       = mk_ir(5'd2, 5'd4, 5'd27, 5'd0, 1'b1);
        bus.NPC_IN   = 32'd100;
        bus.COND_WB  = 1'b1;
        bus.RD_WB    = 5'd27;
        bus.WB_OUT   = 32'd70;
        #1;
        check_val("wb_stall", 32'(bus.STALL), 32'd0);
        tick();
        check_val("wb_reg_a", bus.REG_A, 32'd70);
        check_val("wb_reg_b", bus.REG_B, 32'd0);
        check_val("wb_imm", bus.IMM, 32'h0000_0800);
        check_val("wb_npc", bus.NPC_OUT, 32'd100);
        check_val("wb_opcd", 32'(bus.OPCD), 32'd2);
        check_val("wb_addr", 32'(bus.ADDR_REG), 32'd4);
        check_val("wb_opt", 32'(bus.OPT_BIT), 32'd1);
        check_val("wb_valid", 32'(bus.OUT_VALID), 32'd1);
        check_val("wb_estado", 32'(bus.ESTADO), 32'd1);

        // R27 now from the register file, both operands, negative imm
        clear_bus();
        bus.IN_VALID = 1'b1;
        bus.IR       = mk_ir(5'd7, 5'd9, 5'd27, 5'd27, 1'b0);
        tick();
        check_val("rf_reg_a", bus.REG_A, 32'd70);
        check_val("rf_reg_b", bus.REG_B, 32'd70);
        check_val("rf_imm", bus.IMM, 32'hFFFF_B000);
        check_val("rf_opt", 32'(bus.OPT_BIT), 32'd0);

        // Source priority on rs1=5
        clear_bus();
        bus.IN_VALID    = 1'b1;
        bus.IR          = mk_ir(5'd3, 5'd6, 5'd5, 5'd0, 1'b1);
        bus.WR_EXE      = 1'b1;
        bus.RD_EXE      = 5'd5;
        bus.EXE_OUT     = 32'd60;
        bus.WR_MEM      = 1'b1;
        bus.RD_MEM      = 5'd5;
        bus.MEM_ACC_OUT = 32'd50;
        bus.COND_WB     = 1'b1;
        bus.RD_WB       = 5'd5;
        bus.WB_OUT      = 32'd70;
        #1;
`ifdef ID_FWD_EN
        check_val("pri_exe_stall", 32'(bus.STALL), 32'd0);
        tick();
        check_val("pri_exe_reg_a", bus.REG_A, 32'd60);
        check_val("pri_exe_valid", 32'(bus.OUT_VALID), 32'd1);
`else
        check_val("pri_exe_stall", 32'(bus.STALL), 32'd1);
        tick();
        check_val("pri_exe_valid", 32'(bus.OUT_VALID), 32'd0);
        check_val("pri_exe_estado", 32'(bus.ESTADO), 32'd2);
`endif
        bus.WR_EXE = 1'b0;
        #1;
`ifdef ID_FWD_EN
        check_val("pri_mem_stall", 32'(bus.STALL), 32'd0);
        tick();
        check_val("pri_mem_reg_a", bus.REG_A, 32'd50);
`else
        check_val("pri_mem_stall", 32'(bus.STALL), 32'd1);
        tick();
        check_val("pri_mem_valid", 32'(bus.OUT_VALID), 32'd0);
`endif
        bus.WR_MEM = 1'b0;
        #1;
        check_val("pri_wb_stall", 32'(bus.STALL), 32'd0);
        tick();
        check_val("pri_wb_reg_a", bus.REG_A, 32'd70);
        check_val("pri_wb_valid", 32'(bus.OUT_VALID), 32'd1);
        check_val("pri_wb_estado", 32'(bus.ESTADO), 32'd1);

        // Load-use on rs2=3
        clear_bus();
        bus.IN_VALID = 1'b1;
        bus.IR       = mk_ir(5'd4, 5'd8, 5'd0, 5'd3, 1'b0);
        bus.LOAD_EXE = 1'b1;
        bus.WR_EXE   = 1'b1;
        bus.RD_EXE   = 5'd3;
        bus.EXE_OUT  = 32'hAA;
        #1;
        check_val("lu_stall", 32'(bus.STALL), 32'd1);
        tick();
        check_val("lu_valid", 32'(bus.OUT_VALID), 32'd0);
        check_val("lu_estado", 32'(bus.ESTADO), 32'd2);
        check_val("lu_opcd", 32'(bus.OPCD), 32'd0);
        check_val("lu_addr", 32'(bus.ADDR_REG), 32'd0);
        bus.LOAD_EXE    = 1'b0;
        bus.WR_EXE      = 1'b0;
        bus.WR_MEM      = 1'b1;
        bus.RD_MEM      = 5'd3;
        bus.MEM_ACC_OUT = 32'h1234;
        #1;
`ifdef ID_FWD_EN
        check_val("lu_mem_stall", 32'(bus.STALL), 32'd0);
`else
        check_val("lu_mem_stall", 32'(bus.STALL), 32'd1);
        tick();
        bus.WR_MEM  = 1'b0;
        bus.COND_WB = 1'b1;
        bus.RD_WB   = 5'd3;
        bus.WB_OUT  = 32'h1234;
        #1;
        check_val("lu_wb_stall", 32'(bus.STALL), 32'd0);
`endif
        tick();
        check_val("lu_reg_b", bus.REG_B, 32'h1234);
        check_val("lu_reg_a", bus.REG_A, 32'd0);
        check_val("lu_imm", bus.IMM, 32'h0000_3000);
        check_val("lu_fwd_valid", 32'(bus.OUT_VALID), 32'd1);
        check_val("lu_fwd_addr", 32'(bus.ADDR_REG), 32'd8);

        // R0 source with a writing RD_EXE=0, all-ones immediate
        clear_bus();
        bus.IN_VALID = 1'b1;
        bus.IR       = {5'd9, 5'd10, 5'd0, 1'b0, 16'hFFFF};
        bus.LOAD_EXE = 1'b1;
        bus.WR_EXE   = 1'b1;
        bus.RD_EXE   = 5'd0;
        bus.EXE_OUT  = 32'd99;
        bus.WR_MEM   = 1'b1;
        bus.RD_MEM   = 5'd0;
        #1;
        check_val("r0_stall", 32'(bus.STALL), 32'd0);
        tick();
        check_val("r0_reg_a", bus.REG_A, 32'd0);
        check_val("r0_imm", bus.IMM, 32'hFFFF_FFFF);
        check_val("r0_opcd", 32'(bus.OPCD), 32'd9);
        check_val("r0_valid", 32'(bus.OUT_VALID), 32'd1);

        // FLUSH arriving while stalled
        clear_bus();
        bus.IN_VALID = 1'b1;
        bus.IR       = mk_ir(5'd5, 5'd11, 5'd2, 5'd0, 1'b1);
        bus.LOAD_EXE = 1'b1;
        bus.WR_EXE   = 1'b1;
        bus.RD_EXE   = 5'd2;
        #1;
        check_val("fl_pre_stall", 32'(bus.STALL), 32'd1);
        tick();
        check_val("fl_pre_estado", 32'(bus.ESTADO), 32'd2);
        bus.FLUSH = 1'b1;
        #1;
        check_val("fl_stall", 32'(bus.STALL), 32'd0);
        tick();
        check_val("fl_valid", 32'(bus.OUT_VALID), 32'd0);
        check_val("fl_estado", 32'(bus.ESTADO), 32'd3);

        // Reset while stalled
        bus.FLUSH = 1'b0;
        #1;
        check_val("rs_pre_stall", 32'(bus.STALL), 32'd1);
        rst = 1'b1;
        #1;
        check_val("rs_stall", 32'(bus.STALL), 32'd0);
        tick();
        check_val("rs_estado", 32'(bus.ESTADO), 32'd0);
        check_val("rs_valid", 32'(bus.OUT_VALID), 32'd0);
        rst = 1'b0;
        clear_bus();
        tick();
        check_val("rs_idle_estado", 32'(bus.ESTADO), 32'd4);

        // Register file cleared by reset
        bus.IN_VALID = 1'b1;
        bus.IR       = mk_ir(5'd1, 5'd1, 5'd27, 5'd0, 1'b1);
        tick();
        check_val("rs_rf_reg_a", bus.REG_A, 32'd0);
        check_val("rs_rf_valid", 32'(bus.OUT_VALID), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
